// File: rtl/cpu_axi_master_bridge_if.sv
// cpu_axi_master_bridge_if: AXI4 master-side channel bundle used by the CPU bridge.
interface cpu_axi_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/cpu_axi_master_bridge.sv
// cpu_axi_master_bridge: CPU memory port to AXI4 master (single-beat writes, INCR burst reads).
// Define POSTED_WRITE_EN to release stall once AW and W are accepted instead of on B.
module cpu_axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'h0,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_oe,
  input  logic [DATA_W/8-1:0] i_web,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rbeat_valid,
  output logic [3:0]          o_rbeat_idx,
  output logic                o_stall,
  output logic                o_err,
  cpu_axi_master_bridge_if.master axi
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] SIZE      = 3'($clog2(DATA_W/8));
  localparam int         LINE_B    = BURST_LEN * DATA_W / 8;

  logic [2:0]          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_strb;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                r_aw_done, r_w_done;
  logic [3:0]          r_beat;
  logic w_wr, w_req, w_aw_hs, w_w_hs, w_aw_done, w_w_done, w_wr_done;
  logic w_beat, w_rlast, w_b, w_unused;

  assign w_wr      = ~&i_web;
  assign w_req     = i_oe | w_wr;
  assign w_aw_hs   = r_awvalid & axi.awready;
  assign w_w_hs    = r_wvalid & axi.wready;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;
  assign w_wr_done = w_aw_done & w_w_done;
  assign w_beat    = (r_state == S_RD_DATA) & axi.rvalid;
  assign w_rlast   = w_beat & axi.rlast;
  assign w_b       = (r_state == S_WR_RESP) & axi.bvalid;
  assign w_unused  = ^{axi.rid, axi.bid};

  assign axi.awid    = MASTER_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = SIZE;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_strb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.arid    = MASTER_ID;
  // cache-line fills start at the line base so the INCR burst covers the whole line
  assign axi.araddr  = (BURST_LEN > 1) ? r_addr - (r_addr % ADDR_W'(LINE_B)) : r_addr;
  assign axi.arlen   = 4'(BURST_LEN - 1);
  assign axi.arsize  = SIZE;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  assign o_rdata       = w_beat ? axi.rdata : '0;
  assign o_rbeat_valid = w_beat;
  assign o_rbeat_idx   = w_beat ? r_beat : 4'd0;
  assign o_err         = (w_rlast & (axi.rresp != 2'b00)) | (w_b & (axi.bresp != 2'b00));

`ifdef POSTED_WRITE_EN
  assign o_stall = (r_state == S_IDLE)    ? w_req :
                   (r_state == S_RD_DATA) ? ~w_rlast :
                   (r_state == S_WR_REQ)  ? ~w_wr_done :
                   (r_state == S_WR_RESP) ? w_req : 1'b1;
`else
  assign o_stall = (r_state == S_IDLE)    ? w_req :
                   (r_state == S_RD_DATA) ? ~w_rlast :
                   (r_state == S_WR_RESP) ? ~axi.bvalid : 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_strb  <= ~i_web;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_beat    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_oe) begin
            r_state   <= S_RD_ADDR;
            r_arvalid <= 1'b1;
            r_beat    <= 4'd0;
          end else if (w_wr) begin
            r_state   <= S_WR_REQ;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) begin
            r_state   <= S_RD_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (axi.rvalid) r_beat <= r_beat + 4'd1;
          if (w_rlast) begin
            r_state  <= S_IDLE;
            r_rready <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs) r_wvalid <= 1'b0;
          if (w_wr_done) begin
            r_state   <= S_WR_RESP;
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
          end
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            r_state  <= S_IDLE;
            r_bready <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_axi_master_bridge.sv
// tb_cpu_axi_master_bridge: directed cycle-by-cycle checks of a single-beat and a 4-beat bridge.
module tb_cpu_axi_master_bridge;
`ifdef POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        oe1 = 1'b0, oe4 = 1'b0;
  logic [3:0]  web = 4'hF;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata1, rdata4;
  logic        rbv1, rbv4, stall1, stall4, err1, err4;
  logic [3:0]  idx1, idx4;
  int total = 0, bad = 0;

  cpu_axi_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
  cpu_axi_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) a4 ();

  cpu_axi_master_bridge #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_oe(oe1), .i_web(web), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata1), .o_rbeat_valid(rbv1), .o_rbeat_idx(idx1), .o_stall(stall1),
    .o_err(err1), .axi(a1)
  );
  cpu_axi_master_bridge #(.BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_oe(oe4), .i_web(4'hF), .i_addr(addr), .i_wdata(32'h0),
    .o_rdata(rdata4), .o_rbeat_valid(rbv4), .o_rbeat_idx(idx4), .o_stall(stall4),
    .o_err(err4), .axi(a4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a1.rvalid && a1.rready) assert (a1.rid == 4'h0) else $error("rid mismatch on dut1");
    if (a4.rvalid && a4.rready) assert (a4.rid == 4'h0) else $error("rid mismatch on dut4");
    if (a1.bvalid && a1.bready) assert (a1.bid == 4'h0) else $error("bid mismatch on dut1");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a1.awready = 0; a1.wready = 0; a1.bid = 0; a1.bresp = 0; a1.bvalid = 0; a1.arready = 0;
    a1.rid = 0; a1.rdata = 0; a1.rresp = 0; a1.rlast = 0; a1.rvalid = 0;
    a4.awready = 0; a4.wready = 0; a4.bid = 0; a4.bresp = 0; a4.bvalid = 0; a4.arready = 0;
    a4.rid = 0; a4.rdata = 0; a4.rresp = 0; a4.rlast = 0; a4.rvalid = 0;
    cyc(); cyc(); #1;
    chk("rst_stall", stall1, 0);
    chk("rst_arvalid", a1.arvalid, 0);
    chk("rst_awvalid", a1.awvalid, 0);
    chk("rst_wvalid", a1.wvalid, 0);
    chk("rst_rready", a1.rready, 0);
    chk("rst_bready", a1.bready, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_rbv", rbv1, 0);
    chk("rst_err", err1, 0);
    chk("rst_burst", {a1.awburst, a1.arburst}, 4'b0101);
    chk("rst_size", {a1.awsize, a1.arsize}, 6'o22);
    rst = 0;
    // single read on the one-beat bridge
    cyc(); oe1 = 1; addr = 32'h100; a1.arready = 1; #1;
    chk("rd1_c0_stall", stall1, 1);
    cyc(); a1.rvalid = 1; a1.rlast = 1; a1.rdata = 32'hDEADBEEF; #1;
    chk("rd1_arvalid", a1.arvalid, 1);
    chk("rd1_araddr", a1.araddr, 32'h100);
    chk("rd1_arlen", a1.arlen, 0);
    chk("rd1_c1_stall", stall1, 1);
    chk("rd1_c1_rready", a1.rready, 0);
    cyc(); #1;
    chk("rd1_rready", a1.rready, 1);
    chk("rd1_rbv", rbv1, 1);
    chk("rd1_rdata", rdata1, 32'hDEADBEEF);
    chk("rd1_idx", idx1, 0);
    chk("rd1_stall", stall1, 0);
    chk("rd1_err", err1, 0);
    cyc(); oe1 = 0; a1.rvalid = 0; a1.rlast = 0; #1;
    chk("rd1_idle_rready", a1.rready, 0);
    chk("rd1_idle_stall", stall1, 0);
    chk("rd1_idle_arvalid", a1.arvalid, 0);
    // 4-beat line fill with gapped RVALID
    cyc(); oe4 = 1; addr = 32'h1008; a4.arready = 1; #1;
    chk("bst_c0_stall", stall4, 1);
    cyc(); #1;
    chk("bst_arvalid", a4.arvalid, 1);
    chk("bst_araddr", a4.araddr, 32'h1000);
    chk("bst_arlen", a4.arlen, 3);
    chk("bst_arid", a4.arid, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(); a4.rvalid = i[0]; a4.rlast = (i == 7); a4.rdata = 32'hA000_0000 + 32'(i / 2); #1;
      chk("bst_rready", a4.rready, 1);
      chk("bst_rbv", rbv4, i[0]);
      if (i[0]) begin
        chk("bst_idx", idx4, i / 2);
        chk("bst_rdata", rdata4, 32'hA000_0000 + 32'(i / 2));
      end
      chk("bst_stall", stall4, i != 7);
    end
    cyc(); oe4 = 0; a4.rvalid = 0; a4.rlast = 0; #1;
    chk("bst_end_rready", a4.rready, 0);
    chk("bst_end_stall", stall4, 0);
    // write with AWREADY held off three cycles
    cyc(); web = 4'b1100; addr = 32'h200; wdata = 32'h12345678; a1.awready = 0; a1.wready = 1; #1;
    chk("wr_c0_stall", stall1, 1);
    cyc(); #1;
    chk("wr_awvalid1", a1.awvalid, 1);
    chk("wr_wvalid1", a1.wvalid, 1);
    chk("wr_awaddr1", a1.awaddr, 32'h200);
    chk("wr_wstrb", a1.wstrb, 4'b0011);
    chk("wr_wdata", a1.wdata, 32'h12345678);
    chk("wr_wlast", a1.wlast, 1);
    chk("wr_awlen", a1.awlen, 0);
    cyc(); #1;
    chk("wr_wvalid2", a1.wvalid, 0);
    chk("wr_awvalid2", a1.awvalid, 1);
    chk("wr_awaddr2", a1.awaddr, 32'h200);
    cyc(); a1.awready = 1; #1;
    chk("wr_awvalid3", a1.awvalid, 1);
    chk("wr_awaddr3", a1.awaddr, 32'h200);
    chk("wr_c3_stall", stall1, !POSTED);
    cyc(); a1.awready = 0; a1.bvalid = 1; web = POSTED ? 4'hF : 4'b1100; #1;
    chk("wr_bready", a1.bready, 1);
    chk("wr_awvalid4", a1.awvalid, 0);
    chk("wr_b_stall", stall1, 0);
    chk("wr_err", err1, 0);
    cyc(); web = 4'hF; a1.bvalid = 0; #1;
    chk("wr_bready_off", a1.bready, 0);
    chk("wr_end_stall", stall1, 0);
    // write answered with SLVERR
    cyc(); web = 4'h0; addr = 32'h300; wdata = 32'hCAFEF00D; a1.awready = 1; a1.wready = 1; #1;
    chk("we_c0_stall", stall1, 1);
    cyc(); #1;
    chk("we_awvalid", a1.awvalid, 1);
    chk("we_wstrb", a1.wstrb, 4'hF);
    chk("we_c1_stall", stall1, !POSTED);
    cyc(); web = POSTED ? 4'hF : 4'h0; #1;
    chk("we_bready", a1.bready, 1);
    chk("we_wait_stall", stall1, !POSTED);
    chk("we_wait_err", err1, 0);
    cyc(); a1.bvalid = 1; a1.bresp = 2'b10; #1;
    chk("we_err", err1, 1);
    chk("we_b_stall", stall1, 0);
    cyc(); a1.bvalid = 0; a1.bresp = 0; web = 4'hF; #1;
    chk("we_err_off", err1, 0);
    chk("we_bready_off", a1.bready, 0);
    // read and write requested together: read goes first
    cyc(); oe1 = 1; web = 4'b1110; addr = 32'h400; wdata = 32'h55; #1;
    chk("rw_c0_stall", stall1, 1);
    cyc(); a1.rvalid = 1; a1.rlast = 1; a1.rdata = 32'h11111111; #1;
    chk("rw_arvalid", a1.arvalid, 1);
    chk("rw_awvalid0", a1.awvalid, 0);
    chk("rw_wvalid0", a1.wvalid, 0);
    cyc(); #1;
    chk("rw_rbv", rbv1, 1);
    chk("rw_rdata", rdata1, 32'h11111111);
    chk("rw_rd_stall", stall1, 0);
    cyc(); oe1 = 0; a1.rvalid = 0; a1.rlast = 0; #1;
    chk("rw_wr_stall", stall1, 1);
    chk("rw_awvalid1", a1.awvalid, 0);
    cyc(); a1.bvalid = 1; #1;
    chk("rw_awvalid2", a1.awvalid, 1);
    chk("rw_wvalid2", a1.wvalid, 1);
    chk("rw_awaddr", a1.awaddr, 32'h400);
    chk("rw_wstrb", a1.wstrb, 4'b0001);
    chk("rw_wdata", a1.wdata, 32'h55);
    chk("rw_req_stall", stall1, !POSTED);
    cyc(); web = POSTED ? 4'hF : 4'b1110; #1;
    chk("rw_bready", a1.bready, 1);
    chk("rw_b_stall", stall1, 0);
    cyc(); web = 4'hF; a1.bvalid = 0; #1;
    chk("rw_bready_off", a1.bready, 0);
    chk("rw_arvalid_off", a1.arvalid, 0);
    // reset in the middle of a burst
    cyc(); oe4 = 1; addr = 32'h2000; #1;
    cyc(); a4.rvalid = 1; a4.rdata = 32'h77; a4.rlast = 0; #1;
    chk("mr_arvalid", a4.arvalid, 1);
    cyc(); #1;
    chk("mr_rbv", rbv4, 1);
    chk("mr_idx", idx4, 0);
    cyc(); rst = 1; oe4 = 0; a4.rvalid = 0; #1;
    cyc(); rst = 0; #1;
    chk("mr_rready", a4.rready, 0);
    chk("mr_arvalid_off", a4.arvalid, 0);
    chk("mr_stall", stall4, 0);
    chk("mr_rbv_off", rbv4, 0);
    chk("mr_rdata", rdata4, 0);
    chk("mr_idx_off", idx4, 0);
    chk("mr_err", err4, 0);
    cyc(); oe4 = 1; addr = 32'h2010; #1;
    chk("mr2_c0_stall", stall4, 1);
    cyc(); a4.rvalid = 1; #1;
    chk("mr2_araddr", a4.araddr, 32'h2010);
    for (int i = 0; i < 4; i++) begin
      cyc(); a4.rdata = 32'hB0 + 32'(i); a4.rlast = (i == 3); #1;
      chk("mr2_idx", idx4, i);
      chk("mr2_rdata", rdata4, 32'hB0 + 32'(i));
      chk("mr2_stall", stall4, i != 3);
    end
    cyc(); oe4 = 0; a4.rvalid = 0; a4.rlast = 0; #1;
    chk("mr2_rready_off", a4.rready, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
